// File: rtl/lut_array_pkg.sv
// Shared types and parameter helpers for the run-time reprogrammable LUT neuron array.
// The state enum, derived-width functions and default fan-in wiring live here.
package lut_array_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Upper bound on the packed connection vector the default builder can produce.
   localparam int CONN_MAX = 4096;

   function automatic int calc_aw(input int fanin, input int in_bits);
      return fanin * in_bits;
   endfunction

   function automatic int calc_cw(input int in_ch);
      return (in_ch > 1) ? $clog2(in_ch) : 1;
   endfunction

   function automatic int calc_nw(input int neurons);
      return (neurons > 1) ? $clog2(neurons) : 1;
   endfunction

   // Fan-in k of neuron n reads channel n*fanin+k, wrapping on the channel count.
   function automatic logic [CONN_MAX-1:0] default_conn(input int neurons, input int fanin,
                                                        input int in_ch);
      logic [CONN_MAX-1:0] r;
      int cw;
      int ch;
      r  = '0;
      cw = calc_cw(in_ch);
      for (int i = 0; i < neurons * fanin; i++) begin
         ch = i % in_ch;
         for (int b = 0; b < cw; b++) begin
            if (i * cw + b < CONN_MAX) r[i*cw+b] = ch[b];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lut_neuron_array_rt_ram.sv
// One neuron truth table: 2^AW x DW distributed RAM with a synchronous write port
// and a registered, enable-gated read port whose output register clears on rst.
module lut_neuron_ram #(
   parameter int AW = 6,
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Table contents are deliberately not reset so they survive rst.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lut_neuron_array_rt.sv
// Array of NEURONS reprogrammable LUT neurons behind a 2-stage valid/ready pipeline,
// with a LOAD/RUN/DRAIN controller gating table writes from the host loader.
module lut_neuron_array_rt
   import lut_array_pkg::*;
#(
   parameter int IN_CH    = 16,
   parameter int IN_BITS  = 2,
   parameter int FANIN    = 3,
   parameter int OUT_BITS = 2,
   parameter int NEURONS  = 4,
   parameter logic [NEURONS*FANIN*$clog2(IN_CH)-1:0] CONN =
      (NEURONS*FANIN*$clog2(IN_CH))'(default_conn(NEURONS, FANIN, IN_CH)),
   localparam int AW = calc_aw(FANIN, IN_BITS),
   localparam int CW = calc_cw(IN_CH),
   localparam int NW = calc_nw(NEURONS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_CH*IN_BITS-1:0]     in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NEURONS*OUT_BITS-1:0]  out_data,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [NW-1:0]                cfg_neuron,
   input  logic [AW-1:0]                cfg_addr,
   input  logic [OUT_BITS-1:0]          cfg_data,
   input  logic                         cfg_done,
   input  logic                         cfg_start,
   output logic                         cfg_err,
   output state_t                       dbg_state
);

   // Handshake: a beat transfers on any edge where valid && ready; valid never
   // waits on ready, and a presented output beat holds its data until taken.

   state_t        state, state_nxt;
   logic          s1_valid;
   logic [AW-1:0] s1_idx   [NEURONS];
   logic [AW-1:0] idx_comb [NEURONS];
   logic          s1_adv, s2_adv, in_fire;
   logic          cfg_in_range, cfg_we;

   assign s2_adv    = !out_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = (state == RUN) && s1_adv;
   assign in_fire   = in_valid && in_ready;
   assign cfg_ready = (state == LOAD);
   assign dbg_state = state;

   assign cfg_in_range = 32'(cfg_neuron) < NEURONS;
   assign cfg_we       = (state == LOAD) && cfg_valid && cfg_in_range;

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (cfg_done) state_nxt = RUN;
         RUN:     if (cfg_start) state_nxt = DRAIN;
         DRAIN:   if (!s1_valid && !out_valid) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Gather each neuron's fan-in channels into its table index, fan-in 0 in the LSBs.
   always_comb begin
      logic [CW-1:0] ch;
      ch = '0;
      for (int n = 0; n < NEURONS; n++) idx_comb[n] = '0;
      for (int n = 0; n < NEURONS; n++) begin
         for (int k = 0; k < FANIN; k++) begin
            ch = CONN[(n*FANIN+k)*CW +: CW];
            idx_comb[n][k*IN_BITS +: IN_BITS] = in_data[int'(ch)*IN_BITS +: IN_BITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (s1_adv) s1_valid <= in_fire;
         if (s2_adv) out_valid <= s1_valid;
         if (cfg_valid && ((state != LOAD) || !cfg_in_range)) cfg_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) s1_idx <= idx_comb;
   end

   // The RAM output register doubles as the s2 data register.
   for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
      lut_neuron_ram #(
         .AW(AW),
         .DW(OUT_BITS)
      ) u_ram (
         .clk   (clk),
         .rst   (rst),
         .we    (cfg_we && (cfg_neuron == NW'(n))),
         .waddr (cfg_addr),
         .wdata (cfg_data),
         .re    (s2_adv && s1_valid),
         .raddr (s1_idx[n]),
         .rdata (out_data[n*OUT_BITS +: OUT_BITS])
      );
   end

endmodule

// File: tb/tb_lut_neuron_array_rt.sv
// Bench for lut_neuron_array_rt: table model plus expected-output queue checked
// whenever the DUT presents a beat, including every stalled cycle.
module tb_lut_neuron_array_rt;
   import lut_array_pkg::*;

   localparam int IN_CH    = 16;
   localparam int IN_BITS  = 2;
   localparam int FANIN    = 3;
   localparam int OUT_BITS = 2;
   localparam int NEURONS  = 5;
   localparam int AW       = 6;
   localparam int NW       = 3;
   localparam int OW       = NEURONS * OUT_BITS;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid, in_ready, out_valid, out_ready;
   logic [IN_CH*IN_BITS-1:0]  in_data;
   logic [OW-1:0]             out_data;
   logic                      cfg_valid, cfg_ready, cfg_done, cfg_start, cfg_err;
   logic [NW-1:0]             cfg_neuron;
   logic [AW-1:0]             cfg_addr;
   logic [OUT_BITS-1:0]       cfg_data;
   state_t                    dbg_state;

   logic [OUT_BITS-1:0]       tbl [NEURONS][2**AW];
   logic [OW-1:0]             exp_q [$];
   int                        n_tests = 0;
   int                        n_fail  = 0;
   int                        n_pops  = 0;

   always #5 clk = ~clk;

   lut_neuron_array_rt #(
      .IN_CH(IN_CH), .IN_BITS(IN_BITS), .FANIN(FANIN), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_neuron(cfg_neuron),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
      .cfg_start(cfg_start), .cfg_err(cfg_err), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [OW-1:0] model(input logic [IN_CH*IN_BITS-1:0] d);
      logic [OW-1:0] r;
      logic [AW-1:0] idx;
      r = '0;
      for (int n = 0; n < NEURONS; n++) begin
         idx = '0;
         for (int k = 0; k < FANIN; k++) idx[k*IN_BITS +: IN_BITS] = d[(n*FANIN+k)*IN_BITS +: IN_BITS];
         r[n*OUT_BITS +: OUT_BITS] = tbl[n][idx];
      end
      return r;
   endfunction

   // Inputs change just after negedge; sample 1ns later, then advance one cycle.
   task automatic tick(output bit fired);
      #1;
      fired = in_valid && in_ready;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'(0));
         end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_ready) begin
               void'(exp_q.pop_front());
               n_pops++;
            end
         end
      end
      if (fired) exp_q.push_back(model(in_data));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cfg_write(input int n, input int a, input int d, input bit done,
                            input bit lands);
      bit f;
      cfg_valid  = 1'b1;
      cfg_neuron = NW'(n);
      cfg_addr   = AW'(a);
      cfg_data   = OUT_BITS'(d);
      cfg_done   = done;
      if (lands) tbl[n][a] = OUT_BITS'(d);
      tick(f);
      cfg_valid = 1'b0;
      cfg_done  = 1'b0;
   endtask

   task automatic pulse_done();
      bit f;
      cfg_done = 1'b1;
      tick(f);
      cfg_done = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit f;
      int sent, pops0;
      logic [IN_CH*IN_BITS-1:0] vec2;
      vec2 = 32'h0000_0031;   // ch0=1, ch1=0, ch2=3 -> neuron 0 index 6'b110001

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_valid = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
      cfg_done = 1'b0; cfg_start = 1'b0;
      @(negedge clk); @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_data",  32'(out_data),  32'(0));
      check("rst_cfg_ready", 32'(cfg_ready), 32'(1));
      check("rst_in_ready",  32'(in_ready),  32'(0));
      check("rst_cfg_err",   32'(cfg_err),   32'(0));
      check("rst_state",     32'(dbg_state), 32'(LOAD));
      rst = 1'b0;

      // Neuron 0: only index 49 non-zero; other neurons random except index 0.
      for (int n = 0; n < NEURONS; n++)
         for (int a = 0; a < 2**AW; a++)
            cfg_write(n, a, (n == 0) ? ((a == 49) ? 1 : 0) : ((a == 0) ? 0 : $urandom_range(0, 3)), 1'b0, 1'b1);
      pulse_done();
      check("t2_state_run", 32'(dbg_state), 32'(RUN));

      in_data = vec2; in_valid = 1'b1;
      tick(f);
      check("t2_accept", 32'(f), 32'(1));
      in_valid = 1'b0;
      check("t2_lat1_valid", 32'(out_valid), 32'(0));
      tick(f);
      check("t2_lat2_valid", 32'(out_valid), 32'(1));
      check("t2_lat2_data",  32'(out_data),  32'h1);
      tick(f);

      pops0 = n_pops;
      for (int i = 0; i < 8; i++) begin
         in_data = $urandom; in_valid = 1'b1;
         tick(f);
         check("t3_accept", 32'(f), 32'(1));
      end
      in_valid = 1'b0;
      tick(f); tick(f);
      check("t3_out_count", 32'(n_pops - pops0), 32'(8));

      sent = 0; in_data = $urandom;
      for (int c = 0; c < 60 && (sent < 10 || exp_q.size() > 0); c++) begin
         out_ready = !(c >= 4 && c < 9);
         in_valid  = (sent < 10);
         if (c == 7) begin
            #1;
            check("t4_in_ready_low", 32'(in_ready), 32'(0));
         end
         tick(f);
         if (f) begin
            sent++;
            in_data = $urandom;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("t4_sent",    32'(sent), 32'(10));
      check("t4_drained", 32'(exp_q.size()), 32'(0));

      cfg_write(0, 49, 3, 1'b0, 1'b0);
      check("t5_err_run", 32'(cfg_err), 32'(1));
      in_data = vec2; in_valid = 1'b1;
      tick(f);
      in_valid = 1'b0;
      tick(f);
      check("t5_unchanged", 32'(out_data), 32'h1);
      tick(f); tick(f);
      check("t5_err_sticky", 32'(cfg_err), 32'(1));
      rst = 1'b1; tick(f); rst = 1'b0;
      check("t5_err_cleared", 32'(cfg_err),   32'(0));
      check("t5_state_load",  32'(dbg_state), 32'(LOAD));
      cfg_write(5, 0, 3, 1'b0, 1'b0);
      check("t5_err_range", 32'(cfg_err), 32'(1));
      rst = 1'b1; tick(f); rst = 1'b0;
      pulse_done();

      pops0 = n_pops;
      in_data = $urandom; in_valid = 1'b1;
      tick(f);
      check("t6_accept_a", 32'(f), 32'(1));
      in_data = $urandom; cfg_start = 1'b1;
      tick(f);
      check("t6_accept_b", 32'(f), 32'(1));
      cfg_start = 1'b0; in_data = $urandom;
      check("t6_state_drain", 32'(dbg_state), 32'(DRAIN));
      #1;
      check("t6_in_ready_drain", 32'(in_ready), 32'(0));
      for (int i = 0; i < 10 && dbg_state != LOAD; i++) tick(f);
      in_valid = 1'b0;
      check("t6_state_load", 32'(dbg_state), 32'(LOAD));
      check("t6_cfg_ready",  32'(cfg_ready), 32'(1));
      check("t6_both_out",   32'(n_pops - pops0), 32'(2));
      cfg_write(0, 49, 3, 1'b1, 1'b1);
      check("t6_state_run", 32'(dbg_state), 32'(RUN));
      in_data = vec2; in_valid = 1'b1;
      tick(f);
      in_valid = 1'b0;
      tick(f);
      check("t6_new_entry", 32'(out_data), 32'h3);
      tick(f); tick(f);

      check("final_drain", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
